rrs_interp: RTL and testbench
=============================

RRS_INTERP -- requirements
Module: rrs_interp

Interface
REQ-001 The block SHALL have parameter width_H, default 5: integer bits of the two's-complement sample.
REQ-002 The block SHALL have parameter width_W, default 20: fractional bits of the sample. W = width_H+width_W.
REQ-003 The block SHALL have parameter R, default 32: interpolation factor, a power of two, R >= 2.
REQ-004 The block SHALL have parameter log_R, default 5: log2(R). Any other R or log_R is unsupported.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port data_i_en, input, 1 bit: input sample valid.
REQ-008 The block SHALL have port data_i, input, W bits: signed input sample.
REQ-009 The block SHALL have port data_i_rdy, output, 1 bit: the block can accept a sample this cycle.
REQ-010 The block SHALL have port data_o_en, output, 1 bit: output sample valid, registered.
REQ-011 The block SHALL have port data_o, output, W bits: signed interpolated sample, registered.

Function
REQ-012 The filter SHALL be a second-order recursive running-sum interpolator: two comb stages at the input rate, zero-stuffing by R, then two integrator stages at the output rate.
REQ-013 Comb stage 1 SHALL be c1 = x[n] - x[n-1]; comb stage 2 SHALL be c2 = c1[n] - c1[n-1], with differential delay 1.
REQ-014 All comb and integrator arithmetic SHALL be two's complement, W+2*log_R bits wide, sign-extended from data_i, with modular wrap and no saturation.
REQ-015 data_o SHALL be integrator-2 arithmetically shifted right by log_R and truncated to the low W bits.
REQ-016 The net result SHALL be linear interpolation between consecutive input samples, with unity DC gain.
REQ-017 A sample SHALL be accepted only at a rising edge where data_i_en=1 and data_i_rdy=1; data_i is ignored otherwise.
REQ-018 The state machine SHALL have two states, IDLE and RUN, plus a phase counter of log_R bits.
REQ-019 IDLE: data_i_rdy=1, no output is produced, and the integrators hold their values.
REQ-020 IDLE -> RUN SHALL occur on acceptance, with phase set to 0.
REQ-021 In RUN, phase SHALL increment by 1 each cycle.
REQ-022 In RUN, data_i_rdy SHALL be 1 only when phase = R-1.
REQ-023 At phase R-1 with a sample accepted, the state SHALL stay RUN and phase SHALL wrap to 0.
REQ-024 At phase R-1 with no sample accepted, the state SHALL return to IDLE.
REQ-025 Each RUN cycle SHALL advance the integrators exactly once. Integrator 1 adds c2 when phase = 0 and adds 0 otherwise; integrator 2 adds integrator 1.
REQ-026 Each accepted sample SHALL produce exactly R output samples.
REQ-027 The first of those R samples SHALL have data_o_en=1 at the 3rd rising edge after the acceptance edge; the remaining R-1 follow on consecutive edges.
REQ-028 Inputs accepted back-to-back, one every R cycles, SHALL give a gap-free output stream.
REQ-029 An input gap SHALL pause the output with data_o_en=0 and no change to the filter state; output resumes at the next acceptance plus 3 edges.
REQ-030 data_o SHALL hold its last value while data_o_en=0.
REQ-031 data_i_rdy SHALL be combinational from the state and phase registers only, never from data_i_en.

Reset
REQ-032 While rst_n=0, all registers SHALL be cleared immediately, independent of clk: x[n-1], c1[n-1], c2, both integrators, phase, state=IDLE, and the output pipeline.
REQ-033 During reset, data_o_en SHALL be 0, data_o SHALL be 0 and data_i_rdy SHALL be 1.
REQ-034 Reset asserted mid-burst SHALL abort all pending outputs; no stale data_o_en may appear after release.
REQ-035 After rst_n rises, the first accepted sample SHALL behave as if the previous input were 0.

Verification
REQ-036 Step test, R=4: reset, then feed K=4.0 once, hold data_i_en=0 afterwards -> data_o = 1.0, 2.0, 3.0, 4.0 at acceptance+3..+6, then data_o_en=0.
REQ-037 Ramp test, R=4, back-to-back: inputs 4.0 then 8.0 -> 8 consecutive valid outputs 1, 2, 3, 4, 5, 6, 7, 8 (in units of 1.0), with no gap.
REQ-038 Backpressure test: hold data_i_en=1 constantly -> data_i_rdy pulses once every R cycles; exactly one sample is accepted per pulse; no outputs are lost or duplicated.
REQ-039 Negative/wrap test: inputs of max positive then max negative value -> output falls monotonically, with every value between the two endpoints and no overflow artefact at the output.
REQ-040 Reset test: assert rst_n=0 at phase 2 of a burst -> data_o_en=0 and data_o=0 within the same cycle; after release, feed 4.0 -> output matches the fresh step response of REQ-036.

Source files
------------

// File: rtl/rrs_interp.sv
// Second-order recursive running-sum interpolator: two combs at the input rate,
// zero-stuff by R, two integrators at the output rate, output = int2 >>> log_R.
module rrs_interp #(
    parameter int width_H = 5,
    parameter int width_W = 20,
    parameter int R       = 32,
    parameter int log_R   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_i_en,
    input  logic [width_H+width_W-1:0] data_i,
    output logic                       data_i_rdy,
    output logic                       data_o_en,
    output logic [width_H+width_W-1:0] data_o
);
    localparam int W      = width_H + width_W;
    localparam int AW     = W + 2*log_R;
    localparam int STAGES = 2;
    localparam logic [log_R-1:0] PH_LAST = log_R'(R - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [log_R-1:0]    phase;
    logic signed [AW-1:0] x_prev, c1_prev, c2, int1, int2;
    logic signed [AW-1:0] x_ext, c1, int1_nxt, int2_nxt;
    logic [W-1:0]        s1;
    logic [STAGES:0]     vld_pipe;
    logic                accept;

    assign data_i_rdy = (state == IDLE) || (phase == PH_LAST);
    assign accept     = data_i_en && data_i_rdy;

    assign x_ext    = {{(2*log_R){data_i[W-1]}}, data_i};
    assign c1       = x_ext - x_prev;
    // Zero-stuffing: the comb output enters integrator 1 only on phase 0.
    assign int1_nxt = int1 + ((phase == '0) ? c2 : '0);
    assign int2_nxt = int2 + int1_nxt;

    assign data_o_en = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            x_prev   <= '0;
            c1_prev  <= '0;
            c2       <= '0;
            int1     <= '0;
            int2     <= '0;
            s1       <= '0;
            vld_pipe <= '0;
            data_o   <= '0;
        end else begin
            if (accept) begin
                x_prev  <= x_ext;
                c1_prev <= c1;
                c2      <= c1 - c1_prev;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        phase <= '0;
                    end
                end
                RUN: begin
                    int1 <= int1_nxt;
                    int2 <= int2_nxt;
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (!accept) state <= IDLE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // vld_pipe[0] marks a fresh int2; two register stages follow to the port.
            vld_pipe <= {vld_pipe[STAGES-1:0], state == RUN};
            if (vld_pipe[0]) s1 <= int2[W+log_R-1:log_R];
            if (vld_pipe[1]) data_o <= s1;
        end
    end
endmodule

// File: tb/tb_rrs_interp.sv
// Bench for rrs_interp (R=4): directed step/ramp/wrap/reset/backpressure steps
// plus random traffic, scored against a linear-interpolation reference model.
module tb_rrs_interp;
    localparam int WH = 5;
    localparam int WW = 20;
    localparam int R  = 4;
    localparam int LR = 2;
    localparam int W  = WH + WW;
    localparam logic [W-1:0] ONE = 25'h0100000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         data_i_en = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         data_i_rdy, data_o_en;
    logic [W-1:0] data_o;

    rrs_interp #(.width_H(WH), .width_W(WW), .R(R), .log_R(LR)) dut (
        .clk(clk), .rst_n(rst_n), .data_i_en(data_i_en), .data_i(data_i),
        .data_i_rdy(data_i_rdy), .data_o_en(data_o_en), .data_o(data_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int accepts = 0;
    longint xp = 0;
    int last_acc = -1000;
    logic [W-1:0] last_do = '0;
    logic [W-1:0] exp_val[$];
    int           exp_cyc[$];
    logic [W-1:0] obs[$];

    task automatic chk(input string tag, input longint o, input longint e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Sample k of R between previous input a and new input b: a + k*(b-a)/R, floored.
    function automatic logic [W-1:0] interp(input longint a, input longint b, input int k);
        longint v;
        v = longint'(R) * a + longint'(k) * (b - a);
        v = v >>> LR;
        return v[W-1:0];
    endfunction

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_o_en", data_o_en, 0);
            chk("rst_o", data_o, 0);
            chk("rst_rdy", data_i_rdy, 1);
            exp_val.delete();
            exp_cyc.delete();
            xp = 0;
            last_acc = -1000;
            last_do = '0;
        end else begin
            if (data_o_en) begin
                chk("out_pending", exp_val.size() > 0, 1);
                if (exp_val.size() > 0) begin
                    chk("out_val", data_o, exp_val.pop_front());
                    chk("out_cyc", cyc, exp_cyc.pop_front());
                end
                obs.push_back(data_o);
                last_do = data_o;
            end else begin
                chk("hold", data_o, last_do);
                if (exp_cyc.size() > 0) chk("missing_out", exp_cyc[0] > cyc, 1);
            end
            chk("rdy", data_i_rdy, cyc >= last_acc + R - 1);
            if (data_i_en && data_i_rdy) begin
                longint xn;
                xn = longint'($signed(data_i));
                for (int k = 1; k <= R; k++) begin
                    exp_val.push_back(interp(xp, xn, k));
                    exp_cyc.push_back(cyc + 3 + k);
                end
                xp = xn;
                last_acc = cyc + 1;
                accepts++;
            end
        end
    end

    task automatic send(input logic [W-1:0] x);
        int n;
        n = 0;
        data_i = x;
        data_i_en = 1'b1;
        @(negedge clk);
        while (!data_i_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        data_i_en = 1'b0;
        data_i = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_val.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_val.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic chk_ramp(input string tag, input int n);
        chk({tag, "_count"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            chk(tag, obs[i], longint'(ONE) * (i + 1));
    endtask

    initial begin
        int a0;
        #1;
        chk("rst0_o_en", data_o_en, 0);
        chk("rst0_o", data_o, 0);
        chk("rst0_rdy", data_i_rdy, 1);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Step: 4.0 once -> 1.0, 2.0, 3.0, 4.0
        obs.delete();
        send(ONE * 4);
        drain();
        chk_ramp("step", 4);

        // Ramp back-to-back: 4.0, 8.0 -> 1..8 without gap
        do_reset();
        obs.delete();
        send(ONE * 4);
        send(ONE * 8);
        drain();
        chk_ramp("ramp", 8);

        // Max positive then max negative: second burst falls monotonically
        do_reset();
        obs.delete();
        send(25'h0FFFFFF);
        send(25'h1000000);
        drain();
        chk("wrap_count", obs.size(), 8);
        if (obs.size() == 8) begin
            for (int i = 4; i < 8; i++)
                chk("wrap_mono", $signed(obs[i]) < $signed(obs[i-1]), 1);
            chk("wrap_end", obs[7], 25'h1000000);
            chk("wrap_peak", obs[3], 25'h0FFFFFF);
        end

        // Reset at phase 2 of a burst, then a fresh step
        send(ONE * 4);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_o_en", data_o_en, 0);
        chk("midrst_o", data_o, 0);
        chk("midrst_rdy", data_i_rdy, 1);
        idle(2);
        rst_n = 1'b1;
        idle(6);
        obs.delete();
        send(ONE * 4);
        drain();
        chk_ramp("rst_step", 4);

        // Backpressure: data_i_en held high for 4*R edges from IDLE
        a0 = accepts;
        data_i_en = 1'b1;
        for (int i = 0; i < 4 * R; i++) begin
            data_i = W'($urandom);
            idle(1);
        end
        data_i_en = 1'b0;
        chk("bp_accepts", accepts - a0, 4);
        drain();

        // Random samples with random gaps
        do_reset();
        for (int i = 0; i < 30; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, R + 3));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
